// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, status bit
// positions and the status-register packing helper.
package uart_pkg;

  // Transmitter frame sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // Bit positions inside the status register.
  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_READY = 1;
  localparam int ST_TX_IDLE  = 2;
  localparam int ST_OVR      = 3;

  // The data register is write-only for the transmitter; reads return this.
  localparam logic [7:0] DATA_READ_VAL = 8'h00;

  // Assemble the status byte; there is no receiver, so RX_AVAIL is always 0.
  function automatic logic [7:0] pack_status(input logic ovr,
                                             input logic idle,
                                             input logic ready);
    logic [7:0] s;
    s              = 8'h00;
    s[ST_RX_AVAIL] = 1'b0;
    s[ST_TX_READY] = ready;
    s[ST_TX_IDLE]  = idle;
    s[ST_OVR]      = ovr;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO between CPU writes and the serial shifter.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is still taken when the head leaves on the same edge:
  // the slot being written is the one being read out this cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Pointer advance; wrap-around is plain modular arithmetic on AW+1 bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter on the CPU I/O bus.
// Bus access: a register access happens on the posedge where its select is high;
// rnw=0 writes (only the data register accepts writes), rnw=1 reads, and the
// read value is driven combinationally onto io_bus while the select is held.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [7:0] io_bus,
  input  logic       sel_data,
  input  logic       sel_status,
  input  logic       rnw,
  output logic       tx
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovr_q, ovr_d;

  logic          bit_end;
  logic          fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic          bus_wr, status_rd, overrun_evt;
  logic          bus_drv;
  logic [7:0]    status_val, rd_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (io_bus),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Bus decode. Status writes are deliberately ignored.
  assign bus_wr      = sel_data && !rnw;
  assign status_rd   = sel_status && rnw;
  assign fifo_push   = bus_wr;
  assign overrun_evt = bus_wr && fifo_full && !fifo_pop;

  assign status_val = pack_status(ovr_q, fifo_empty && (state_q == S_IDLE), !fifo_full);
  assign rd_data    = sel_status ? status_val : DATA_READ_VAL;
  assign bus_drv    = rnw && (sel_data || sel_status);
  assign io_bus     = bus_drv ? rd_data : 8'hzz;

  assign tx      = tx_q;
  assign bit_end = (cnt_q == CNT_LAST);

  // Sticky overrun: set by a dropped byte, cleared by a sampled status read.
  always_comb begin
    ovr_d = ovr_q;
    if (status_rd)   ovr_d = 1'b0;
    if (overrun_evt) ovr_d = 1'b1;
  end

  // State register plus the datapath registers advanced by the sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic: each of START/DATA/STOP lasts CLK_DIV cycles; STOP chains
  // straight into the next START when another byte is waiting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: the line level for the coming cycle, registered into tx_q.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule
